// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the multi-cycle data-memory responder.
// Holds default/legal read latency, field widths and the single-outstanding FSM state type.
// No ports; imported by dmem_resp_4c, dmem_resp_stage and the request/response interface.
package dmem_pkg;

  // Request/response field widths
  localparam int DMEM_DWIDTH = 16;
  localparam int DMEM_AWIDTH = 16;

  // Read latency: default and legal bounds
  localparam int DMEM_LAT_DEF = 4;
  localparam int DMEM_LAT_MIN = 1;
  localparam int DMEM_LAT_MAX = 8;

  // Single-outstanding read controller state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_resp_4c_if.sv
// dmem_resp_4c_if: request (valid/ready) and read-response bundle for the data-memory responder.
// Latency: n/a (wires only). Backpressure: req_ready only; responses cannot be stalled.
// Ports: req_valid/req_wr/req_addr/req_wdata (requester -> memory), req_ready,
//        rsp_valid/rsp_rdata/rsp_addr and busy (memory -> requester).
interface dmem_resp_4c_if #(
  parameter int DWIDTH = dmem_pkg::DMEM_DWIDTH,
  parameter int AWIDTH = dmem_pkg::DMEM_AWIDTH
) ();

  logic              req_valid;
  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic [AWIDTH-1:0] rsp_addr;
  logic              busy;

  // Requester side
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr, busy
  );

  // Memory side
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr, busy
  );

endinterface

// File: rtl/dmem_resp_stage.sv
// dmem_resp_stage: one valid/data/address register of the read-response pipeline.
// Latency: 1 cycle. Backpressure: none, advances every cycle; synchronous clear drops the entry.
// Ports: clk, clr (sync, active-high), src_vld/src_dat/src_addr in, vld/dat/addr registered out.
module dmem_resp_stage
  import dmem_pkg::*;
#(
  parameter int DWIDTH = DMEM_DWIDTH,
  parameter int AWIDTH = DMEM_AWIDTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              src_vld,
  input  logic [DWIDTH-1:0] src_dat,
  input  logic [AWIDTH-1:0] src_addr,
  output logic              vld,
  output logic [DWIDTH-1:0] dat,
  output logic [AWIDTH-1:0] addr
);

  always_ff @(posedge clk) begin
    if (clr) begin
      vld  <= 1'b0;
      dat  <= '0;
      addr <= '0;
    end else begin
      vld <= src_vld;
      // Payload only moves with a valid entry so the last stage holds the
      // most recent response while rsp_valid is low.
      if (src_vld) begin
        dat  <= src_dat;
        addr <= src_addr;
      end
    end
  end

endmodule

// File: rtl/dmem_resp_4c.sv
// dmem_resp_4c: word-addressed data memory; writes commit at acceptance, reads return data+address.
// Latency: reads respond exactly LATENCY cycles after acceptance; writes produce no response.
// Backpressure: req_ready (registered); no response backpressure. Macro DMEM_RESP_PIPELINED_EN
//   selects one request per cycle; otherwise a 2-state FSM allows a single outstanding read.
// Ports: clk, rst (sync, active-high), bus (dmem_resp_4c_if.slave: req_*, rsp_*, busy).
module dmem_resp_4c
  import dmem_pkg::*;
#(
  parameter int DWIDTH  = DMEM_DWIDTH,
  parameter int AWIDTH  = DMEM_AWIDTH,
  parameter int LATENCY = DMEM_LAT_DEF   // legal DMEM_LAT_MIN..DMEM_LAT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  dmem_resp_4c_if.slave bus
);

  localparam int WORDS = 2 ** (AWIDTH - 1);

  logic [DWIDTH-1:0] mem [WORDS];

  logic              ready_q;
  logic [AWIDTH-2:0] word_idx;
  logic              req_acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              unused_addr_lsb;

  // Index 0 of each chain is the request side; index k is stage k's output.
  logic [LATENCY:0]             chain_vld;
  logic [LATENCY:0][DWIDTH-1:0] chain_dat;
  logic [LATENCY:0][AWIDTH-1:0] chain_addr;

  assign word_idx        = bus.req_addr[AWIDTH-1:1];
  assign unused_addr_lsb = bus.req_addr[0];

  // Nothing is accepted in a reset cycle, so a write presented there is lost.
  assign req_acc = bus.req_valid & ready_q & ~rst;
  assign rd_acc  = req_acc & ~bus.req_wr;
  assign wr_acc  = req_acc & bus.req_wr;

  // Array is not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[word_idx] <= bus.req_wdata;
    end
  end

  // The read sees the array as it stands before this edge; a write can never
  // share the edge with a read since only one request is accepted per cycle.
  assign chain_vld[0]  = rd_acc;
  assign chain_dat[0]  = mem[word_idx];
  assign chain_addr[0] = {word_idx, 1'b0};

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    dmem_resp_stage #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
    ) u_stage (
      .clk      (clk),
      .clr      (rst),
      .src_vld  (chain_vld[g]),
      .src_dat  (chain_dat[g]),
      .src_addr (chain_addr[g]),
      .vld      (chain_vld[g+1]),
      .dat      (chain_dat[g+1]),
      .addr     (chain_addr[g+1])
    );
  end

  assign bus.rsp_valid = chain_vld[LATENCY];
  assign bus.rsp_rdata = chain_dat[LATENCY];
  assign bus.rsp_addr  = chain_addr[LATENCY];
  assign bus.busy      = |chain_vld[LATENCY:1];
  assign bus.req_ready = ready_q;

`ifdef DMEM_RESP_PIPELINED_EN

  // Fully pipelined: the request side never stalls once out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b1;
    end
  end

`else

  dmem_state_e state;
  dmem_state_e state_nxt;
  logic        last_load;

  // High on the edge that loads the final stage, i.e. the edge raising rsp_valid.
  // With LATENCY=1 this is the acceptance itself, so the FSM never leaves IDLE
  // and reads can be taken every cycle.
  assign last_load = chain_vld[LATENCY-1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rd_acc && !last_load) state_nxt = ST_WAIT;
      ST_WAIT: if (last_load)            state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is registered from the next state so it rises in the same
  // cycle rsp_valid does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
    end
  end

`endif

endmodule

// File: tb/tb_dmem_resp_4c.sv
// tb_dmem_resp_4c: directed and randomized stimulus for dmem_resp_4c against a queue-based model.
// Latency: model predicts each read response at acceptance cycle + LAT - 1 (sampled on negedge).
// Backpressure: requests are held until accepted; ready is predicted by the model.
module tb_dmem_resp_4c;
  import dmem_pkg::*;

  localparam int LAT = 4;

  logic clk;
  logic rst;

  dmem_resp_4c_if #(.DWIDTH(16), .AWIDTH(16)) bus ();

  dmem_resp_4c #(
    .DWIDTH  (16),
    .AWIDTH  (16),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] dat;
    logic [15:0] addr;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mm [int];
  int          cyc = 0;
  int          vec = 0;
  int          errs = 0;
  int          last_rd = 0;
  bit          rd_seen = 0;
  bit          last_acc = 0;
  logic [15:0] last_dat = '0;
  logic [15:0] last_addr = '0;

  // Ready in the current cycle: blocked only while an earlier read is still
  // short of the cycle in which its response appears.
  function automatic bit m_ready();
`ifdef DMEM_RESP_PIPELINED_EN
    return 1'b1;
`else
    return !(rd_seen && (cyc <= last_rd + LAT - 2));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit exp_v;
    bit exp_busy;
    exp_busy = (q.size() > 0);
    exp_v    = (q.size() > 0) && (q[0].due == cyc);
    if (exp_v) begin
      last_dat  = q[0].dat;
      last_addr = q[0].addr;
    end
    chk("req_ready", bus.req_ready, m_ready());
    chk("rsp_valid", bus.rsp_valid, exp_v);
    chk("busy",      bus.busy,      exp_busy);
    chk("rsp_rdata", bus.rsp_rdata, last_dat);
    chk("rsp_addr",  bus.rsp_addr,  last_addr);
    if (exp_v) void'(q.pop_front());
  endtask

  task automatic tick();
    bit          acc;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    acc = !rst && bus.req_valid && m_ready();
    wr  = bus.req_wr;
    a   = bus.req_addr;
    d   = bus.req_wdata;
    @(posedge clk);
    cyc++;
    last_acc = acc;
    if (rst) begin
      q.delete();
      rd_seen   = 0;
      last_dat  = '0;
      last_addr = '0;
    end else if (acc) begin
      if (wr) begin
        mm[int'(a >> 1)] = d;
      end else begin
        q.push_back('{due: cyc + LAT - 1, dat: mm[int'(a >> 1)], addr: {a[15:1], 1'b0}});
        rd_seen = 1;
        last_rd = cyc;
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input bit v, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = v;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic send(input bit wr, input logic [15:0] a, input logic [15:0] d, output int acc_cyc);
    acc_cyc = -1;
    drive(1'b1, wr, a, d);
    for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
      tick();
      if (last_acc) acc_cyc = cyc;
    end
    bus.req_valid = 1'b0;
    chk("send_accepted", (acc_cyc >= 0), 1);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int c1;
    int c2;
    int gap;
    logic [15:0] a;

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    idle(1);

    // Preload the working region and the top word
    for (int i = 0; i < 32; i++) send(1'b1, 16'(2 * i), 16'($urandom), c1);
    send(1'b1, 16'hFFFE, 16'hA5C3, c1);

    // Write then read the next cycle
    send(1'b1, 16'h0010, 16'hBEEF, c1);
    send(1'b0, 16'h0010, 16'h0000, c2);
    chk("wr_rd_adjacent", c2 - c1, 1);
    idle(LAT + 1);

    // Odd address aliases to the even word
    send(1'b1, 16'h0021, 16'h1234, c1);
    send(1'b0, 16'h0020, 16'h0000, c2);
    idle(LAT + 1);

    // Two reads back to back with valid held
    send(1'b0, 16'h0004, 16'h0000, c1);
    send(1'b0, 16'h0006, 16'h0000, c2);
`ifdef DMEM_RESP_PIPELINED_EN
    gap = 1;
`else
    gap = LAT;
`endif
    chk("rd_gap", c2 - c1, gap);
    idle(LAT + 1);

    // Read burst to four consecutive words
    for (int i = 0; i < 4; i++) send(1'b0, 16'(2 * i), 16'h0000, c1);
    idle(LAT + 1);

    // Top word, read through the odd byte address
    send(1'b0, 16'hFFFF, 16'h0000, c1);
    idle(LAT + 1);

    // Reset two cycles after a read is accepted: the read is dropped
    send(1'b0, 16'h0010, 16'h0000, c1);
    idle(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(LAT + 2);
    send(1'b0, 16'h0010, 16'h0000, c1);
    idle(LAT + 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!(bus.req_valid && !last_acc)) begin
        a = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(16'hFFFE, 16'hFFFF))
                                         : 16'($urandom_range(0, 63));
        drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), a, 16'($urandom));
      end
      rst = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 1'b0;
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
